// File: rtl/aes_key_sched_ctrl.sv
// aes_key_sched_ctrl
// Sequences AES-128 key expansion around a shared subWord unit. A cipher
// key is accepted on a valid/ready handshake, then round keys 0..10 are
// emitted one per output handshake.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. The producer holds its data stable and keeps valid high
// until that edge; ready may change freely.
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   key        cipher key, word0 = key[127:96], byte0 of a word = its MSB byte
//   key_valid  key offered
//   key_ready  idle and able to accept a key
//   rk         current round key, same word/byte order as key
//   rk_idx     round index of rk, 0..10
//   rk_last    rk_idx == 10 while rk_valid
//   rk_valid   rk valid
//   rk_ready   consumer accepts rk
//
// Build option: AES_KEY_SCHED_SERIAL_SBOX_EN replaces the four-lane subWord
// with one sbox walked over the four bytes (SUB lasts 4 cycles instead of 1).
// Ports and round-key values are identical in both builds.
module aes_key_sched_ctrl #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key,
  input  logic         key_valid,
  output logic         key_ready,
  output logic [127:0] rk,
  output logic [3:0]   rk_idx,
  output logic         rk_last,
  output logic         rk_valid,
  input  logic         rk_ready
);

  typedef enum logic [1:0] {S_IDLE, S_SUB, S_EMIT} state_t;

  // Internal state is kept in r_state so a checker can probe it hierarchically.
  state_t      r_state;
  logic [31:0] r_w0, r_w1, r_w2, r_w3;
  logic [3:0]  r_rk_idx;
  logic [7:0]  r_rcon;
  logic        r_key_ready, r_rk_valid, r_rk_last;

  logic [31:0] w_rot, w_sub, w_t;
  logic [31:0] w_n0, w_n1, w_n2, w_n3;
  logic        w_sub_done;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (a^2 * a^4 * ... * a^128); 0 maps to 0.
  // Followed by the FIPS-197 affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq, inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1B : 8'h00);
  endfunction

  assign w_rot = {r_w3[23:0], r_w3[31:24]};

`ifdef AES_KEY_SCHED_SERIAL_SBOX_EN
  logic [1:0]  r_cnt;
  logic [23:0] r_sub;    // sbox results of bytes 0..2, byte0 in the MSBs
  logic [7:0]  w_sbox_in, w_sbox_out;

  always_comb begin
    w_sbox_in = w_rot[31:24];
    case (r_cnt)
      2'd0:    w_sbox_in = w_rot[31:24];
      2'd1:    w_sbox_in = w_rot[23:16];
      2'd2:    w_sbox_in = w_rot[15:8];
      default: w_sbox_in = w_rot[7:0];
    endcase
  end

  assign w_sbox_out = sbox(w_sbox_in);
  // Byte 3 goes straight from the sbox into the word update on the last beat.
  assign w_sub      = {r_sub, w_sbox_out};
  assign w_sub_done = (r_cnt == 2'd3);
`else
  assign w_sub = {sbox(w_rot[31:24]), sbox(w_rot[23:16]),
                  sbox(w_rot[15:8]),  sbox(w_rot[7:0])};
  assign w_sub_done = 1'b1;
`endif

  // Next round key: the four words chain through each other's new value.
  assign w_t  = w_sub ^ {r_rcon, 24'h000000};
  assign w_n0 = r_w0 ^ w_t;
  assign w_n1 = r_w1 ^ w_n0;
  assign w_n2 = r_w2 ^ w_n1;
  assign w_n3 = r_w3 ^ w_n2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_key_ready <= 1'b1;
      r_rk_valid  <= 1'b0;
      r_rk_last   <= 1'b0;
      r_rk_idx    <= 4'd0;
      r_rcon      <= 8'h01;
      r_w0        <= '0;
      r_w1        <= '0;
      r_w2        <= '0;
      r_w3        <= '0;
`ifdef AES_KEY_SCHED_SERIAL_SBOX_EN
      r_cnt       <= 2'd0;
      r_sub       <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (key_valid) begin
            r_w0        <= key[127:96];
            r_w1        <= key[95:64];
            r_w2        <= key[63:32];
            r_w3        <= key[31:0];
            r_rk_idx    <= 4'd0;
            r_rcon      <= 8'h01;
            r_key_ready <= 1'b0;
            r_rk_valid  <= 1'b1;
            r_rk_last   <= 1'b0;
            r_state     <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (rk_ready) begin
            r_rk_valid <= 1'b0;
            r_rk_last  <= 1'b0;
            if (r_rk_idx == 4'(NR)) begin
              r_key_ready <= 1'b1;
              r_state     <= S_IDLE;
            end else begin
`ifdef AES_KEY_SCHED_SERIAL_SBOX_EN
              r_cnt <= 2'd0;
`endif
              r_state <= S_SUB;
            end
          end
        end
        S_SUB: begin
          if (w_sub_done) begin
            r_w0       <= w_n0;
            r_w1       <= w_n1;
            r_w2       <= w_n2;
            r_w3       <= w_n3;
            r_rk_idx   <= r_rk_idx + 4'd1;
            r_rcon     <= xtime(r_rcon);
            r_rk_valid <= 1'b1;
            r_rk_last  <= (r_rk_idx == 4'(NR - 1));
            r_state    <= S_EMIT;
          end
`ifdef AES_KEY_SCHED_SERIAL_SBOX_EN
          else begin
            r_cnt <= r_cnt + 2'd1;
            case (r_cnt)
              2'd0:    r_sub[23:16] <= w_sbox_out;
              2'd1:    r_sub[15:8]  <= w_sbox_out;
              default: r_sub[7:0]   <= w_sbox_out;
            endcase
          end
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign key_ready = r_key_ready;
  assign rk        = {r_w0, r_w1, r_w2, r_w3};
  assign rk_idx    = r_rk_idx;
  assign rk_last   = r_rk_last;
  assign rk_valid  = r_rk_valid;

endmodule
